radial_zone_cfg_fp16: RTL and testbench

Double-buffered configuration controller for the radial confidence/zone masking stage of the DFDD pipeline. It accepts per-zone threshold writes (confidence threshold `c`, data threshold `z`, squared radius `r_squared`) and the optical center over a ready/valid write port into a shadow bank. On command, it commits the shadow bank to the active bank only at a frame boundary, so every frame is masked with one consistent parameter set. The active-bank outputs drive the masking stage's `c_i`, `z_i`, `r_squared_i`, `col_center_i` and `row_center_i` inputs.

---
 rtl/radial_zone_cfg_fp16.sv | 169 ++++++++++++++++
 tb/tb_radial_zone_cfg_fp16.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/radial_zone_cfg_fp16.sv
// radial_zone_cfg_fp16: double-buffered radial zone configuration.
// Writes land in a shadow bank; a commit copies the whole shadow bank to the
// active bank in one cycle at the next frame end, so each frame sees one
// consistent parameter set.
// Optional feature macro: RADIAL_CFG_READBACK_EN adds a registered readback port.
module radial_zone_cfg_fp16 #(
  parameter int NO_ZONES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [7:0]  cfg_zone_i,
  input  logic [1:0]  cfg_field_i,
  input  logic [31:0] cfg_data_i,
  output logic        cfg_err_o,
  input  logic        commit_i,
  output logic        pending_o,
  output logic        commit_done_o,
  input  logic        valid_i,
  input  logic [15:0] col_i,
  input  logic [15:0] row_i,
  input  logic [15:0] last_col_i,
  input  logic [15:0] last_row_i,
  output logic [15:0] c_o         [NO_ZONES],
  output logic [15:0] z_o         [NO_ZONES],
  output logic [17:0] r_squared_o [NO_ZONES],
  output logic [15:0] col_center_o,
  output logic [15:0] row_center_o
`ifdef RADIAL_CFG_READBACK_EN
  ,
  input  logic        rd_bank_i,
  input  logic [7:0]  rd_zone_i,
  input  logic [1:0]  rd_field_i,
  output logic [31:0] rd_data_o
`endif
);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t state_q, state_d;

  logic [15:0] sh_c_q   [NO_ZONES];
  logic [15:0] sh_z_q   [NO_ZONES];
  logic [17:0] sh_r2_q  [NO_ZONES];
  logic [15:0] sh_col_q;
  logic [15:0] sh_row_q;

  logic                wr_en;
  logic                fe;
  logic [NO_ZONES-1:0] zone_hit;
  logic                err_d, err_q;

  assign wr_en = cfg_valid_i && (state_q == IDLE);
  assign fe    = valid_i && (col_i == last_col_i) && (row_i == last_row_i);

  // One-hot zone decode for per-zone field writes; the center field has no zone.
  for (genvar gi = 0; gi < NO_ZONES; gi++) begin : g_zone_hit
    assign zone_hit[gi] = wr_en && (cfg_field_i != 2'd3) && (cfg_zone_i == 8'(gi));
  end

  // A per-zone write that hits no zone is consumed but flagged.
  assign err_d = wr_en && (cfg_field_i != 2'd3) && (zone_hit == '0);

  // State register and error pulse flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: commit waits for a frame end seen while already pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_i) state_d = PENDING;
      PENDING: if (fe) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cfg_ready_o   = (state_q == IDLE);
  assign pending_o     = (state_q != IDLE);
  assign commit_done_o = (state_q == APPLY);
  assign cfg_err_o     = err_q;

  // Shadow bank: one field per accepted write, upper data bits truncated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NO_ZONES; i++) begin
        sh_c_q[i]  <= '0;
        sh_z_q[i]  <= '0;
        sh_r2_q[i] <= '0;
      end
      sh_col_q <= '0;
      sh_row_q <= '0;
    end else begin
      for (int i = 0; i < NO_ZONES; i++) begin
        if (zone_hit[i]) begin
          case (cfg_field_i)
            2'd0:    sh_c_q[i]  <= cfg_data_i[15:0];
            2'd1:    sh_z_q[i]  <= cfg_data_i[15:0];
            2'd2:    sh_r2_q[i] <= cfg_data_i[17:0];
            default: ;
          endcase
        end
      end
      if (wr_en && (cfg_field_i == 2'd3)) begin
        sh_col_q <= cfg_data_i[15:0];
        sh_row_q <= cfg_data_i[31:16];
      end
    end
  end

  // Active bank: atomic copy of the whole shadow bank in the APPLY cycle only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NO_ZONES; i++) begin
        c_o[i]         <= '0;
        z_o[i]         <= '0;
        r_squared_o[i] <= '0;
      end
      col_center_o <= '0;
      row_center_o <= '0;
    end else if (state_q == APPLY) begin
      for (int i = 0; i < NO_ZONES; i++) begin
        c_o[i]         <= sh_c_q[i];
        z_o[i]         <= sh_z_q[i];
        r_squared_o[i] <= sh_r2_q[i];
      end
      col_center_o <= sh_col_q;
      row_center_o <= sh_row_q;
    end
  end

`ifdef RADIAL_CFG_READBACK_EN
  logic [31:0] rd_mux;

  // Readback select; out-of-range zones fall through to zero.
  always_comb begin
    rd_mux = '0;
    if (rd_field_i == 2'd3) begin
      rd_mux = rd_bank_i ? {row_center_o, col_center_o} : {sh_row_q, sh_col_q};
    end else begin
      for (int i = 0; i < NO_ZONES; i++) begin
        if (rd_zone_i == 8'(i)) begin
          case (rd_field_i)
            2'd0:    rd_mux = {16'd0, rd_bank_i ? c_o[i] : sh_c_q[i]};
            2'd1:    rd_mux = {16'd0, rd_bank_i ? z_o[i] : sh_z_q[i]};
            default: rd_mux = {14'd0, rd_bank_i ? r_squared_o[i] : sh_r2_q[i]};
          endcase
        end
      end
    end
  end

  // Registered readback data, one cycle behind the request.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_o <= '0;
    else       rd_data_o <= rd_mux;
  end
`endif

endmodule

// File: tb/tb_radial_zone_cfg_fp16.sv
// Testbench for radial_zone_cfg_fp16 (default build, readback disabled).
// A behavioural model tracks shadow/active banks and the commit handshake;
// every negedge the DUT outputs are compared against it, and directed
// literal checks pin the model on the key scenarios.
module tb_radial_zone_cfg_fp16;
  localparam int NZ = 4;
  localparam logic [15:0] LC = 16'd639;
  localparam logic [15:0] LR = 16'd479;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_zone = '0;
  logic [1:0]  cfg_field = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_err;
  logic        commit = 1'b0;
  logic        pending;
  logic        commit_done;
  logic        pix_valid = 1'b0;
  logic [15:0] col = '0;
  logic [15:0] row = '0;
  logic [15:0] c_o  [NZ];
  logic [15:0] z_o  [NZ];
  logic [17:0] r2_o [NZ];
  logic [15:0] col_center, row_center;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  radial_zone_cfg_fp16 #(.NO_ZONES(NZ)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_zone_i(cfg_zone), .cfg_field_i(cfg_field), .cfg_data_i(cfg_data),
    .cfg_err_o(cfg_err),
    .commit_i(commit), .pending_o(pending), .commit_done_o(commit_done),
    .valid_i(pix_valid), .col_i(col), .row_i(row),
    .last_col_i(LC), .last_row_i(LR),
    .c_o(c_o), .z_o(z_o), .r_squared_o(r2_o),
    .col_center_o(col_center), .row_center_o(row_center)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_sh_c [NZ], m_sh_z [NZ], m_ac_c [NZ], m_ac_z [NZ];
  logic [17:0] m_sh_r [NZ], m_ac_r [NZ];
  logic [15:0] m_sh_col, m_sh_row, m_ac_col, m_ac_row;
  bit m_pend, m_apply, m_err, started = 0;

  always @(posedge clk) begin : model
    bit rdy, fe, err;
    started = 1;
    if (rst) begin
      for (int i = 0; i < NZ; i++) begin
        m_sh_c[i] = 0; m_sh_z[i] = 0; m_sh_r[i] = 0;
        m_ac_c[i] = 0; m_ac_z[i] = 0; m_ac_r[i] = 0;
      end
      m_sh_col = 0; m_sh_row = 0; m_ac_col = 0; m_ac_row = 0;
      m_pend = 0; m_apply = 0; m_err = 0;
    end else begin
      rdy = !m_pend;
      fe  = pix_valid && col == LC && row == LR;
      err = 0;
      if (rdy && cfg_valid) begin
        if (cfg_field == 2'd3) begin
          m_sh_col = cfg_data[15:0];
          m_sh_row = cfg_data[31:16];
        end else if (int'(cfg_zone) < NZ) begin
          if (cfg_field == 2'd0) m_sh_c[cfg_zone] = cfg_data[15:0];
          else if (cfg_field == 2'd1) m_sh_z[cfg_zone] = cfg_data[15:0];
          else m_sh_r[cfg_zone] = cfg_data[17:0];
        end else begin
          err = 1;
        end
      end
      if (m_apply) begin
        m_ac_c = m_sh_c; m_ac_z = m_sh_z; m_ac_r = m_sh_r;
        m_ac_col = m_sh_col; m_ac_row = m_sh_row;
        m_apply = 0; m_pend = 0;
      end else if (m_pend && fe) begin
        m_apply = 1;
      end else if (rdy && commit) begin
        m_pend = 1;
      end
      m_err = err;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("ready", 32'(cfg_ready), 32'(!m_pend));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("commit_done", 32'(commit_done), 32'(m_apply));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("col_center", 32'(col_center), 32'(m_ac_col));
      chk("row_center", 32'(row_center), 32'(m_ac_row));
      for (int i = 0; i < NZ; i++) begin
        chk($sformatf("c[%0d]", i), 32'(c_o[i]), 32'(m_ac_c[i]));
        chk($sformatf("z[%0d]", i), 32'(z_o[i]), 32'(m_ac_z[i]));
        chk($sformatf("r2[%0d]", i), 32'(r2_o[i]), 32'(m_ac_r[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] zone, input logic [1:0] field, input logic [31:0] data);
    cfg_valid = 1'b1; cfg_zone = zone; cfg_field = field; cfg_data = data;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic do_fe();
    pix_valid = 1'b1; col = LC; row = LR;
    step();
    pix_valid = 1'b0; col = 16'd0; row = 16'd0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_c1", 32'(c_o[1]), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);

    // Write then commit with no frame end yet; junk upper bits are truncated.
    do_write(8'd1, 2'd0, 32'h1234_3C00);
    do_write(8'd1, 2'd2, 32'hABC0_2710);
    do_commit();
    step(); step();
    chk("pend_hold", 32'(pending), 32'h1);
    chk("pend_c1", 32'(c_o[1]), 32'h0);

    // Stall: write held while pending, accepted only after APPLY.
    cfg_valid = 1'b1; cfg_zone = 8'd0; cfg_field = 2'd1; cfg_data = 32'h0000_5000;
    step();
    chk("stall_ready", 32'(cfg_ready), 32'h0);
    do_fe();
    chk("apply_done", 32'(commit_done), 32'h1);
    step();
    chk("apply_c1", 32'(c_o[1]), 32'h3C00);
    chk("apply_r2_1", 32'(r2_o[1]), 32'd10000);
    chk("idle_ready", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    chk("stall_not_active", 32'(z_o[0]), 32'h0);

    // Bad zone: consumed, single err pulse, no aliasing into zone 3.
    do_write(8'd7, 2'd0, 32'h0000_FFFF);
    chk("err_pulse", 32'(cfg_err), 32'h1);
    step();
    chk("err_clear", 32'(cfg_err), 32'h0);
    do_write(8'd9, 2'd3, 32'h00F0_0140);
    chk("center_no_err", 32'(cfg_err), 32'h0);
    do_commit();
    do_fe();
    chk("apply2_done", 32'(commit_done), 32'h1);
    step();
    chk("z0_after", 32'(z_o[0]), 32'h5000);
    chk("c3_no_alias", 32'(c_o[3]), 32'h0);
    chk("col_center", 32'(col_center), 32'h0140);
    chk("row_center", 32'(row_center), 32'h00F0);

    // Write and commit in the same cycle: write is included.
    cfg_valid = 1'b1; cfg_zone = 8'd2; cfg_field = 2'd0; cfg_data = 32'h0000_4400;
    commit = 1'b1;
    step();
    cfg_valid = 1'b0; commit = 1'b0;
    step();
    do_fe();
    step();
    chk("same_cyc_c2", 32'(c_o[2]), 32'h4400);

    // Commit and frame end in the same cycle: waits for the next frame end.
    do_write(8'd3, 2'd2, 32'd5);
    commit = 1'b1; pix_valid = 1'b1; col = LC; row = LR;
    step();
    commit = 1'b0; pix_valid = 1'b0; col = 16'd0; row = 16'd0;
    step();
    chk("cfe_pending", 32'(pending), 32'h1);
    chk("cfe_no_done", 32'(commit_done), 32'h0);
    step();
    chk("cfe_r2_3_old", 32'(r2_o[3]), 32'h0);
    do_fe();
    chk("cfe_done", 32'(commit_done), 32'h1);
    step();
    chk("cfe_r2_3_new", 32'(r2_o[3]), 32'd5);

    // Reset while pending discards the commit and zeroes the active bank.
    do_write(8'd0, 2'd0, 32'h0000_7777);
    do_commit();
    step();
    chk("pre_rst_pending", 32'(pending), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_pending", 32'(pending), 32'h0);
    chk("rst_mid_c2", 32'(c_o[2]), 32'h0);
    chk("rst_mid_ready", 32'(cfg_ready), 32'h1);
    step();
    do_fe();
    chk("rst_no_done", 32'(commit_done), 32'h0);
    step();
    chk("rst_no_done2", 32'(commit_done), 32'h0);
    chk("rst_c0", 32'(c_o[0]), 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
